// File: rtl/usr_shift_engine.sv
// Multi-cycle universal shift/rotate engine with a valid/ready operation handshake.
// Optional abort input is compiled in when USR_SHIFT_ABORT_EN is defined.
module usr_shift_engine #(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       mode,
   input  logic [AW-1:0]    amt,
   input  logic [WIDTH-1:0] in,
   input  logic             msb_in,
   input  logic             lsb_in,
`ifdef USR_SHIFT_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ASR  = 3'b101;
   localparam logic [2:0] M_ROL  = 3'b110;

   localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
   localparam logic [AW-1:0] AMT_ONE = AW'(1);

   state_t           r_state;
   logic [AW-1:0]    r_count;
   logic [2:0]       r_mode;
   logic [WIDTH-1:0] r_out;
   logic             r_serial;
   logic             r_done;

   state_t           w_state_next;
   logic [AW-1:0]    w_count_next;
   logic [2:0]       w_mode_next;
   logic [WIDTH-1:0] w_out_next;
   logic             w_serial_next;
   logic             w_done_next;

   logic             w_accept;
   logic             w_is_shift;
   logic [AW-1:0]    w_amt_clamped;
   logic [WIDTH-1:0] w_step_out;
   logic             w_step_serial;
   logic             w_abort;

`ifdef USR_SHIFT_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign op_ready   = (r_state == ST_IDLE) && !Clear;
   assign busy       = (r_state == ST_SHIFT);
   assign done       = r_done;
   assign out        = r_out;
   assign serial_out = r_serial;

   assign w_accept      = op_valid && op_ready;
   assign w_amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;

   // HOLD, LOAD and the reserved code complete at the acceptance edge
   always_comb begin
      w_is_shift = 1'b0;
      case (mode)
         M_SHR, M_SHL, M_ROR, M_ASR, M_ROL: w_is_shift = 1'b1;
         default:                           w_is_shift = 1'b0;
      endcase
   end

   // One single-bit step of the latched operation; serial inputs are taken live
   always_comb begin
      w_step_out    = r_out;
      w_step_serial = r_serial;
      case (r_mode)
         M_SHR: begin
            w_step_out    = {msb_in, r_out[WIDTH-1:1]};
            w_step_serial = r_out[0];
         end
         M_SHL: begin
            w_step_out    = {r_out[WIDTH-2:0], lsb_in};
            w_step_serial = r_out[WIDTH-1];
         end
         M_ROR: begin
            w_step_out    = {r_out[0], r_out[WIDTH-1:1]};
            w_step_serial = r_out[0];
         end
         M_ASR: begin
            w_step_out    = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
            w_step_serial = r_out[0];
         end
         M_ROL: begin
            w_step_out    = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            w_step_serial = r_out[WIDTH-1];
         end
         default: begin
            w_step_out    = r_out;
            w_step_serial = r_serial;
         end
      endcase
   end

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_mode_next   = r_mode;
      w_out_next    = r_out;
      w_serial_next = r_serial;
      w_done_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_is_shift && (amt != '0)) begin
                  w_state_next = ST_SHIFT;
                  w_count_next = w_amt_clamped;
                  w_mode_next  = mode;
               end else begin
                  w_done_next = 1'b1;
                  if (mode == M_LOAD) begin
                     w_out_next = in;
                  end
               end
            end
         end
         ST_SHIFT: begin
            if (w_abort) begin
               // Keep the partially shifted value and report completion
               w_state_next = ST_IDLE;
               w_count_next = '0;
               w_done_next  = 1'b1;
            end else begin
               w_out_next    = w_step_out;
               w_serial_next = w_step_serial;
               w_count_next  = r_count - AMT_ONE;
               if (r_count == AMT_ONE) begin
                  w_state_next = ST_IDLE;
                  w_done_next  = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Clear) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_mode   <= M_HOLD;
         r_out    <= '0;
         r_serial <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_count  <= w_count_next;
         r_mode   <= w_mode_next;
         r_out    <= w_out_next;
         r_serial <= w_serial_next;
         r_done   <= w_done_next;
      end
   end

endmodule

// File: tb/tb_usr_shift_engine.sv
// Self-checking bench for usr_shift_engine (WIDTH=8): vector table plus scoreboard,
// with hand-written sequences for Clear, back-to-back loads and mid-shift Clear.
module tb_usr_shift_engine;

   localparam int WIDTH = 8;
   localparam int AW    = $clog2(WIDTH) + 1;

   logic             CLK = 1'b0;
   logic             Clear;
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       mode;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] in_d;
   logic             msb_in;
   logic             lsb_in;
   logic             abort;
   logic [WIDTH-1:0] out_d;
   logic             serial_out;
   logic             busy;
   logic             done;

   usr_shift_engine #(.WIDTH(WIDTH)) dut (
      .CLK        (CLK),
      .Clear      (Clear),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .mode       (mode),
      .amt        (amt),
      .in         (in_d),
      .msb_in     (msb_in),
      .lsb_in     (lsb_in),
`ifdef USR_SHIFT_ABORT_EN
      .abort      (abort),
`endif
      .out        (out_d),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]       mode;
      logic [AW-1:0]    amt;
      logic [WIDTH-1:0] din;
      logic             msb;
      logic             lsb;
      logic [WIDTH-1:0] exp_out;
      logic             exp_ser;
      int               exp_busy;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] out;
      logic             ser;
      int               busy;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[18];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Issue one operation, keep poking op_valid while busy, and score at done
   task automatic run_op(input vec_t v, input string tag);
      int   busy_cycles = 0;
      int   ready_viol  = 0;
      bit   got         = 0;
      exp_t e;
      @(negedge CLK);
      chk({tag, " ready"}, 32'(op_ready), 32'd1);
      op_valid = 1'b1;
      mode     = v.mode;
      amt      = v.amt;
      in_d     = v.din;
      msb_in   = v.msb;
      lsb_in   = v.lsb;
      sb.push_back('{v.exp_out, v.exp_ser, v.exp_busy});
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge CLK);
         if (done) begin
            got      = 1;
            op_valid = 1'b0;
            e        = sb.pop_front();
            chk({tag, " out"}, 32'(out_d), 32'(e.out));
            chk({tag, " serial"}, 32'(serial_out), 32'(e.ser));
            chk({tag, " busy_cycles"}, 32'(busy_cycles), 32'(e.busy));
            chk({tag, " ready_during_busy"}, 32'(ready_viol), 32'd0);
         end else begin
            if (busy) busy_cycles++;
            if (op_ready) ready_viol++;
            op_valid = 1'b1;
            mode     = 3'b011;
            amt      = 4'd3;
            in_d     = 8'h00;
         end
      end
      if (!got) begin
         op_valid = 1'b0;
         chk({tag, " done_timeout"}, 32'd0, 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         @(negedge CLK);
         chk({tag, " done_single"}, 32'(done), 32'd0);
      end
   endtask

   initial begin
      int done_seen;
      Clear = 1'b1; op_valid = 1'b0; mode = '0; amt = '0; in_d = '0;
      msb_in = 1'b0; lsb_in = 1'b0; abort = 1'b0;

      //               mode    amt   din    msb   lsb   out    ser  busy
      tbl[0]  = '{3'b011, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 0};
      tbl[1]  = '{3'b001, 4'd3,  8'h00, 1'b1, 1'b0, 8'hF4, 1'b1, 3};
      tbl[2]  = '{3'b011, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 0};
      tbl[3]  = '{3'b110, 4'd8,  8'h00, 1'b1, 1'b0, 8'h81, 1'b1, 8};
      tbl[4]  = '{3'b110, 4'd15, 8'h00, 1'b1, 1'b0, 8'h81, 1'b1, 8};
      tbl[5]  = '{3'b011, 4'd0,  8'h90, 1'b0, 1'b0, 8'h90, 1'b1, 0};
      tbl[6]  = '{3'b101, 4'd2,  8'h00, 1'b0, 1'b1, 8'hE4, 1'b0, 2};
      tbl[7]  = '{3'b010, 4'd0,  8'h00, 1'b0, 1'b1, 8'hE4, 1'b0, 0};
      tbl[8]  = '{3'b100, 4'd3,  8'h00, 1'b0, 1'b1, 8'h9C, 1'b1, 3};
      tbl[9]  = '{3'b111, 4'd5,  8'h00, 1'b0, 1'b0, 8'h9C, 1'b1, 0};
      tbl[10] = '{3'b000, 4'd3,  8'h55, 1'b0, 1'b0, 8'h9C, 1'b1, 0};
      tbl[11] = '{3'b010, 4'd2,  8'h00, 1'b0, 1'b1, 8'h73, 1'b0, 2};
      tbl[12] = '{3'b001, 4'd8,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8};
      tbl[13] = '{3'b011, 4'd0,  8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 0};
      tbl[14] = '{3'b100, 4'd8,  8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 8};
      tbl[15] = '{3'b011, 4'd0,  8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 0};
      tbl[16] = '{3'b101, 4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8};
      tbl[17] = '{3'b011, 4'd0,  8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 0};

      // Random activity, then Clear held for two cycles
      repeat (2) @(negedge CLK);
      Clear = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         op_valid = 1'($urandom_range(0, 1));
         mode     = 3'($urandom_range(0, 7));
         amt      = AW'($urandom_range(0, 15));
         in_d     = 8'($urandom_range(0, 255));
         msb_in   = 1'($urandom_range(0, 1));
         lsb_in   = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      op_valid = 1'b0;
      Clear    = 1'b1;
      #1 chk("clear ready_low_0", 32'(op_ready), 32'd0);
      @(negedge CLK);
      chk("clear out", 32'(out_d), 32'h00);
      chk("clear serial", 32'(serial_out), 32'd0);
      chk("clear busy", 32'(busy), 32'd0);
      chk("clear done", 32'(done), 32'd0);
      chk("clear ready_low_1", 32'(op_ready), 32'd0);
      @(negedge CLK);
      chk("clear ready_low_2", 32'(op_ready), 32'd0);
      Clear = 1'b0;
      #1 chk("clear ready_after", 32'(op_ready), 32'd1);

      // Back-to-back single-cycle loads
      @(negedge CLK);
      op_valid = 1'b1; mode = 3'b011; amt = '0; in_d = 8'hA5;
      @(negedge CLK);
      chk("b2b out0", 32'(out_d), 32'hA5);
      chk("b2b done0", 32'(done), 32'd1);
      chk("b2b busy0", 32'(busy), 32'd0);
      chk("b2b ready0", 32'(op_ready), 32'd1);
      in_d = 8'h3C;
      @(negedge CLK);
      op_valid = 1'b0;
      chk("b2b out1", 32'(out_d), 32'h3C);
      chk("b2b done1", 32'(done), 32'd1);
      @(negedge CLK);
      chk("b2b done_end", 32'(done), 32'd0);
      chk("b2b out_hold", 32'(out_d), 32'h3C);

      for (int i = 0; i < 18; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      // SHL by 5 from 8'hFF, Clear after the second step
      @(negedge CLK);
      op_valid = 1'b1; mode = 3'b010; amt = 4'd5; in_d = 8'h00; lsb_in = 1'b0;
      @(negedge CLK);
      op_valid = 1'b0;
      chk("abortclr busy_e0", 32'(busy), 32'd1);
      chk("abortclr out_e0", 32'(out_d), 32'hFF);
      @(negedge CLK);
      chk("abortclr out_e1", 32'(out_d), 32'hFE);
      @(negedge CLK);
      chk("abortclr out_e2", 32'(out_d), 32'hFC);
      chk("abortclr serial_e2", 32'(serial_out), 32'd1);
      Clear = 1'b1;
      @(negedge CLK);
      chk("abortclr out", 32'(out_d), 32'h00);
      chk("abortclr done", 32'(done), 32'd0);
      chk("abortclr busy", 32'(busy), 32'd0);
      chk("abortclr serial", 32'(serial_out), 32'd0);
      Clear = 1'b0;
      #1 chk("abortclr ready", 32'(op_ready), 32'd1);
      done_seen = 0;
      repeat (6) begin
         @(negedge CLK);
         if (done) done_seen++;
      end
      chk("abortclr no_done", 32'(done_seen), 32'd0);
      chk("abortclr out_stays", 32'(out_d), 32'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
